m2vside2: RTL and testbench

Stage-2 side-information sequencer for the MPEG2 video decoder. Accepts one macroblock descriptor at a time from stage 1 (motion vector, position, intra flag, coded_block_pattern) into a 2-entry queue. It expands the head descriptor into six per-block records (blocks 0..5, 4:2:0) on the s2_* outputs. It advances one block per block_start pulse, which is the same pulse that makes stage 3 latch s2_*. It sits directly upstream of the stage-3 side-info container and drives its s2_* inputs.

---
 rtl/m2vside2.sv | 121 ++++++++++++
 tb/tb_m2vside2.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/m2vside2.sv
// Stage-2 side-information sequencer: queues up to two macroblock descriptors
// and expands the head one into six per-block records, one per block_start.
module m2vside2 #(
    parameter int MVH_WIDTH = 16,
    parameter int MVV_WIDTH = 16,
    parameter int MBX_WIDTH = 6,
    parameter int MBY_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [MVH_WIDTH-1:0] s1_mv_h,
    input  logic [MVV_WIDTH-1:0] s1_mv_v,
    input  logic [MBX_WIDTH-1:0] s1_mb_x,
    input  logic [MBY_WIDTH-1:0] s1_mb_y,
    input  logic                 s1_mb_intra,
    input  logic [5:0]           s1_cbp,
    input  logic                 s1_enable,
    input  logic                 s1_valid,
    output logic                 s1_ready,
    input  logic                 block_start,
    output logic [MVH_WIDTH-1:0] s2_mv_h,
    output logic [MVV_WIDTH-1:0] s2_mv_v,
    output logic [MBX_WIDTH-1:0] s2_mb_x,
    output logic [MBY_WIDTH-1:0] s2_mb_y,
    output logic                 s2_mb_intra,
    output logic [2:0]           s2_block,
    output logic                 s2_coded,
    output logic                 s2_enable,
    output logic                 s2_mb_last,
    output logic                 s2_empty
);

    logic [1:0]           r_count;
    logic                 r_rdPtr;
    logic                 r_wrPtr;
    logic [2:0]           r_blk;
    logic [MVH_WIDTH-1:0] r_mvH   [2];
    logic [MVV_WIDTH-1:0] r_mvV   [2];
    logic [MBX_WIDTH-1:0] r_mbX   [2];
    logic [MBY_WIDTH-1:0] r_mbY   [2];
    logic                 r_intra [2];
    logic [5:0]           r_cbp   [2];
    logic                 r_en    [2];

    logic w_push;
    logic w_headValid;
    logic w_advance;
    logic w_pop;

    assign s1_ready    = (r_count < 2'd2);
    assign w_push      = s1_valid & s1_ready;
    assign w_headValid = (r_count != 2'd0);
    assign w_advance   = block_start & w_headValid;
    assign w_pop       = w_advance & (r_blk == 3'd5);

    // Intra macroblocks always carry coefficients in every block, so cbp is forced on store.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 2'd0;
            r_rdPtr <= 1'b0;
            r_wrPtr <= 1'b0;
            r_blk   <= 3'd0;
            for (int i = 0; i < 2; i++) begin
                r_mvH[i]   <= '0;
                r_mvV[i]   <= '0;
                r_mbX[i]   <= '0;
                r_mbY[i]   <= '0;
                r_intra[i] <= 1'b0;
                r_cbp[i]   <= 6'd0;
                r_en[i]    <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_mvH[r_wrPtr]   <= s1_mv_h;
                r_mvV[r_wrPtr]   <= s1_mv_v;
                r_mbX[r_wrPtr]   <= s1_mb_x;
                r_mbY[r_wrPtr]   <= s1_mb_y;
                r_intra[r_wrPtr] <= s1_mb_intra;
                r_cbp[r_wrPtr]   <= s1_mb_intra ? 6'b111111 : s1_cbp;
                r_en[r_wrPtr]    <= s1_enable;
                r_wrPtr          <= ~r_wrPtr;
            end
            if (w_advance) begin
                r_blk <= w_pop ? 3'd0 : r_blk + 3'd1;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        s2_mv_h     = '0;
        s2_mv_v     = '0;
        s2_mb_x     = '0;
        s2_mb_y     = '0;
        s2_mb_intra = 1'b0;
        s2_block    = 3'd0;
        s2_coded    = 1'b0;
        s2_enable   = 1'b0;
        s2_mb_last  = 1'b0;
        s2_empty    = ~w_headValid;
        if (w_headValid) begin
            s2_mv_h     = r_mvH[r_rdPtr];
            s2_mv_v     = r_mvV[r_rdPtr];
            s2_mb_x     = r_mbX[r_rdPtr];
            s2_mb_y     = r_mbY[r_rdPtr];
            s2_mb_intra = r_intra[r_rdPtr];
            s2_block    = r_blk;
            s2_coded    = r_cbp[r_rdPtr][3'd5 - r_blk];
            s2_enable   = r_en[r_rdPtr];
            s2_mb_last  = (r_blk == 3'd5);
        end
    end

endmodule

// File: tb/tb_m2vside2.sv
// Scoreboard bench for m2vside2: each accepted descriptor expands into six
// expected block records; a negedge monitor compares and retires them.
module tb_m2vside2;

    typedef struct packed {
        logic [15:0] mvh;
        logic [15:0] mvv;
        logic [5:0]  x;
        logic [4:0]  y;
        logic        intra;
        logic [2:0]  blk;
        logic        coded;
        logic        en;
        logic        mbLast;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] s1_mv_h = '0;
    logic [15:0] s1_mv_v = '0;
    logic [5:0]  s1_mb_x = '0;
    logic [4:0]  s1_mb_y = '0;
    logic        s1_mb_intra = 1'b0;
    logic [5:0]  s1_cbp = '0;
    logic        s1_enable = 1'b0;
    logic        s1_valid = 1'b0;
    logic        s1_ready;
    logic        block_start = 1'b0;
    logic [15:0] s2_mv_h;
    logic [15:0] s2_mv_v;
    logic [5:0]  s2_mb_x;
    logic [4:0]  s2_mb_y;
    logic        s2_mb_intra;
    logic [2:0]  s2_block;
    logic        s2_coded;
    logic        s2_enable;
    logic        s2_mb_last;
    logic        s2_empty;

    int   errors = 0;
    int   checks = 0;
    rec_t expQ[$];
    rec_t actRec;
    rec_t newRec;
    int   outstanding;
    logic expReady;

    m2vside2 dut (
        .clk(clk), .reset(reset),
        .s1_mv_h(s1_mv_h), .s1_mv_v(s1_mv_v), .s1_mb_x(s1_mb_x), .s1_mb_y(s1_mb_y),
        .s1_mb_intra(s1_mb_intra), .s1_cbp(s1_cbp), .s1_enable(s1_enable),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .block_start(block_start),
        .s2_mv_h(s2_mv_h), .s2_mv_v(s2_mv_v), .s2_mb_x(s2_mb_x), .s2_mb_y(s2_mb_y),
        .s2_mb_intra(s2_mb_intra), .s2_block(s2_block), .s2_coded(s2_coded),
        .s2_enable(s2_enable), .s2_mb_last(s2_mb_last), .s2_empty(s2_empty)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor/scoreboard: compare the presented record, retire it on block_start,
    // then expand a descriptor accepted this cycle into its six expected records.
    always @(negedge clk) begin
        if (!reset) begin
            outstanding = (expQ.size() + 5) / 6;
            expReady    = (outstanding < 2);
            actRec = '{s2_mv_h, s2_mv_v, s2_mb_x, s2_mb_y, s2_mb_intra,
                       s2_block, s2_coded, s2_enable, s2_mb_last};
            checkOutput("s1_ready", 64'(s1_ready), 64'(expReady));
            checkOutput("s2_empty", 64'(s2_empty), 64'(expQ.size() == 0));
            if (expQ.size() == 0) begin
                checkOutput("s2_idle_record", 64'(actRec), 64'(0));
            end else begin
                checkOutput("s2_record", 64'(actRec), 64'(expQ[0]));
                if (block_start) void'(expQ.pop_front());
            end
            if (s1_valid && expReady) begin
                for (int b = 0; b < 6; b++) begin
                    newRec.mvh    = s1_mv_h;
                    newRec.mvv    = s1_mv_v;
                    newRec.x      = s1_mb_x;
                    newRec.y      = s1_mb_y;
                    newRec.intra  = s1_mb_intra;
                    newRec.blk    = 3'(b);
                    newRec.coded  = s1_mb_intra ? 1'b1 : s1_cbp[5-b];
                    newRec.en     = s1_enable;
                    newRec.mbLast = (b == 5);
                    expQ.push_back(newRec);
                end
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [5:0] x, input logic [4:0] y,
                                 input logic intra, input logic [5:0] cbp, input logic en,
                                 input logic bs);
        s1_valid    = v;
        s1_mv_h     = 16'($urandom);
        s1_mv_v     = 16'($urandom);
        s1_mb_x     = x;
        s1_mb_y     = y;
        s1_mb_intra = intra;
        s1_cbp      = cbp;
        s1_enable   = en;
        block_start = bs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic bs, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 6'd0, 5'd0, 1'b0, 6'd0, 1'b0, bs);
    endtask

    task automatic drain();
        int budget;
        budget = 100;
        while (expQ.size() != 0 && budget > 0) begin
            idle(1'b1, 1);
            budget--;
        end
        idle(1'b0, 1);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_timeout: %0d records left, expected 0", expQ.size());
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1'b0, 2);

        // Reset while a macroblock is part way through its blocks.
        applyStimulus(1'b1, 6'd9, 5'd3, 1'b0, 6'b110011, 1'b1, 1'b0);
        idle(1'b1, 3);
        reset = 1'b1;
        s1_valid = 1'b0;
        block_start = 1'b0;
        #1;
        checkOutput("rst_empty", 64'(s2_empty), 64'(1));
        checkOutput("rst_ready", 64'(s1_ready), 64'(1));
        checkOutput("rst_block", 64'(s2_block), 64'(0));
        checkOutput("rst_enable", 64'(s2_enable), 64'(0));
        checkOutput("rst_fields", 64'({s2_mv_h, s2_mv_v, s2_mb_x, s2_mb_y, s2_mb_intra, s2_coded, s2_mb_last}), 64'(0));
        expQ.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1'b0, 1);

        applyStimulus(1'b1, 6'd5, 5'd2, 1'b0, 6'b101001, 1'b1, 1'b0);
        idle(1'b1, 6);
        idle(1'b0, 1);

        applyStimulus(1'b1, 6'd7, 5'd1, 1'b1, 6'b000000, 1'b1, 1'b0);
        drain();

        // Two pushes fill the queue; C is held until space opens.
        applyStimulus(1'b1, 6'd10, 5'd4, 1'b0, 6'b111000, 1'b1, 1'b0);
        applyStimulus(1'b1, 6'd11, 5'd5, 1'b0, 6'b000111, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 6'd12, 5'd6, 1'b0, 6'b010101, 1'b1, 1'b1);
        applyStimulus(1'b1, 6'd12, 5'd6, 1'b0, 6'b010101, 1'b1, 1'b0);
        drain();

        // Pop at block 5 coincides with a push of D.
        applyStimulus(1'b1, 6'd20, 5'd8, 1'b0, 6'b100001, 1'b1, 1'b0);
        idle(1'b1, 5);
        applyStimulus(1'b1, 6'd21, 5'd9, 1'b0, 6'b011110, 1'b1, 1'b1);
        idle(1'b0, 1);
        drain();

        idle(1'b1, 4);
        applyStimulus(1'b1, 6'd33, 5'd17, 1'b0, 6'b001100, 1'b1, 1'b0);
        idle(1'b0, 1);
        drain();

        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 6'($urandom), 5'($urandom),
                          1'($urandom_range(0, 3) == 0), 6'($urandom),
                          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
